// File: rtl/genblk_pkg.sv
// Shared definitions for the generate-cascade FIFO: depth lookup and counter width.
package genblk_pkg;

  localparam int CNT_W = 3;

  // Maps the elaboration-time select P to the number of storage entries.
  function automatic int depth_of(input int p);
    case (p)
      1:       return 2;
      2:       return 3;
      3:       return 5;
      default: return 7;
    endcase
  endfunction

endpackage

// File: rtl/genblk_wrap_ctr.sv
// Modulo-DEPTH pointer. Wraps explicitly at DEPTH-1 because depths 3, 5 and 7
// are not powers of two.
module genblk_wrap_ctr
  import genblk_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_value;

  // Advance on inc, returning to zero after the last entry.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_value <= '0;
    else if (inc)
      r_value <= (r_value == CNT_W'(DEPTH - 1)) ? '0 : r_value + CNT_W'(1);
  end

  assign value = r_value;

endmodule

// File: rtl/genblk_cascade_fifo.sv
// Synchronous FIFO whose storage lives in named generate blocks picked by P.
// A second cascade on P reaches that storage by hierarchical name for the
// write port, the read port and the $bits size report.
module genblk_cascade_fifo
  import genblk_pkg::*;
#(
  parameter int P     = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       count,
  output logic [31:0]      depth_bits
);

  localparam int DEPTH = depth_of(P);
  localparam int AW    = $clog2(DEPTH);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_wr_ptr;
  logic [CNT_W-1:0] w_rd_ptr;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_unused;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);

  // Reset cycle suppresses both handshakes so nothing is written or consumed.
  assign w_push = in_valid  & in_ready  & rst_n;
  assign w_pop  = out_valid & out_ready & rst_n;

  // Pointers never exceed DEPTH-1, so only the low AW bits address storage.
  assign w_wr_idx = w_wr_ptr[AW-1:0];
  assign w_rd_idx = w_rd_ptr[AW-1:0];
  assign w_unused = &{1'b0, w_wr_ptr, w_rd_ptr};

  genblk_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_push),
    .value (w_wr_ptr)
  );

  genblk_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pop),
    .value (w_rd_ptr)
  );

  // Storage: exactly one of these blocks exists after elaboration.
  if (P == 1) begin : blk1
    logic [WIDTH-1:0] mem [2];
  end else if (P == 2) begin : blk2
    logic [WIDTH-1:0] mem [3];
  end else if (P == 3) begin : blk3
    logic [WIDTH-1:0] mem [5];
  end else begin : blk4
    logic [WIDTH-1:0] mem [7];
  end

  // Access: mirrors the storage cascade and touches blkN.mem by name.
  if (P == 1) begin : acc1
    // Write the accepted word; storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (w_push) blk1.mem[w_wr_idx] <= in_data;
    end
    assign w_rd_data  = blk1.mem[w_rd_idx];
    assign depth_bits = 32'($bits(blk1.mem));
  end else if (P == 2) begin : acc2
    // Write the accepted word; storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (w_push) blk2.mem[w_wr_idx] <= in_data;
    end
    assign w_rd_data  = blk2.mem[w_rd_idx];
    assign depth_bits = 32'($bits(blk2.mem));
  end else if (P == 3) begin : acc3
    // Write the accepted word; storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (w_push) blk3.mem[w_wr_idx] <= in_data;
    end
    assign w_rd_data  = blk3.mem[w_rd_idx];
    assign depth_bits = 32'($bits(blk3.mem));
  end else begin : acc4
    // Write the accepted word; storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (w_push) blk4.mem[w_wr_idx] <= in_data;
    end
    assign w_rd_data  = blk4.mem[w_rd_idx];
    assign depth_bits = 32'($bits(blk4.mem));
  end

  // Occupancy: simultaneous push and pop cancel; never exceeds DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_count <= '0;
    else
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  assign count    = r_count;
  assign out_data = out_valid ? w_rd_data : '0;

endmodule

// File: tb/tb_genblk_cascade_fifo.sv
// Bench for genblk_cascade_fifo: one instance per P (WIDTH=8) plus a WIDTH=4
// set for the size report, checked against an ordered-list model.
module tb_genblk_cascade_fifo;

  logic                 clk = 1'b0;
  logic [3:0]           rst_n;
  logic [3:0]           in_valid;
  logic [3:0]           in_ready;
  logic [3:0][7:0]      in_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [3:0][7:0]      out_data;
  logic [3:0][2:0]      count;
  logic [3:0][31:0]     depth_bits;

  logic [3:0]           n_in_ready;
  logic [3:0]           n_out_valid;
  logic [3:0][3:0]      n_out_data;
  logic [3:0][2:0]      n_count;
  logic [3:0][31:0]     n_depth_bits;

  int tests = 0;
  int fails = 0;

  // Model: each FIFO is an ordered list; element 0 is the oldest.
  int         mcnt [4];
  logic [7:0] mq   [4][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    genblk_cascade_fifo #(.P(g), .WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(out_data[g]), .count(count[g]), .depth_bits(depth_bits[g])
    );
    genblk_cascade_fifo #(.P(g), .WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(1'b0), .in_valid(1'b0), .in_ready(n_in_ready[g]),
      .in_data(4'h0), .out_valid(n_out_valid[g]), .out_ready(1'b0),
      .out_data(n_out_data[g]), .count(n_count[g]), .depth_bits(n_depth_bits[g])
    );
  end

  function automatic int dep(input int d);
    case (d)
      1: return 2;
      2: return 3;
      3: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic logic [7:0] m_front(input int d);
    return (mcnt[d] != 0) ? mq[d][0] : 8'h00;
  endfunction

  // One clock on instance d; all other instances idle. Model follows the rules.
  task automatic tick(input int d, input logic iv, input logic [7:0] din,
                      input logic ordy, input logic rst);
    bit push, pop;
    in_valid = '0; out_ready = '0; rst_n = '1;
    in_valid[d] = iv; in_data[d] = din; out_ready[d] = ordy; rst_n[d] = rst;
    push = rst && iv && (mcnt[d] != dep(d));
    pop  = rst && ordy && (mcnt[d] != 0);
    @(posedge clk);
    if (!rst) mcnt[d] = 0;
    else begin
      if (pop) begin
        for (int i = 0; i < 7; i++) mq[d][i] = mq[d][i+1];
        mcnt[d]--;
      end
      if (push) begin
        mq[d][mcnt[d]] = din;
        mcnt[d]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = '0; in_valid = '0; out_ready = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = '1;
    for (int d = 0; d < 4; d++) mcnt[d] = 0;
    for (int d = 0; d < 4; d++) begin
      tests++; if (depth_bits[d] !== 32'(dep(d) * 8)) begin fails++; $display("FAIL reset_depth_bits[%0d] got %0d want %0d", d, depth_bits[d], dep(d)*8); end
      tests++; if (count[d] !== 3'd0) begin fails++; $display("FAIL reset_count[%0d] got %0d want 0", d, count[d]); end
      tests++; if (out_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, out_valid[d]); end
      tests++; if (in_ready[d] !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d] got %b want 1", d, in_ready[d]); end
      tests++; if (out_data[d] !== 8'h00) begin fails++; $display("FAIL reset_out_data[%0d] got %h want 00", d, out_data[d]); end
    end
  endtask

  // P=3: fill five entries, then a sixth push must be refused.
  task automatic test_full();
    for (int i = 0; i < 5; i++) tick(3, 1'b1, 8'h11 + 8'(i), 1'b0, 1'b1);
    tests++; if (count[3] !== 3'd5) begin fails++; $display("FAIL full_count got %0d want 5", count[3]); end
    tests++; if (in_ready[3] !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready[3]); end
    tick(3, 1'b1, 8'h16, 1'b0, 1'b1);
    tests++; if (count[3] !== 3'd5) begin fails++; $display("FAIL full_refuse_count got %0d want 5", count[3]); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_data[3] !== 8'h11 + 8'(i)) begin fails++; $display("FAIL full_drain[%0d] got %h want %h", i, out_data[3], 8'h11 + 8'(i)); end
      tick(3, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    tests++; if (out_valid[3] !== 1'b0) begin fails++; $display("FAIL full_empty_after_drain got %b want 0", out_valid[3]); end
  endtask

  // P=2: pointers pass the 2 -> 0 boundary.
  task automatic test_wrap();
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3;
    tick(2, 1'b1, 8'hA0, 1'b0, 1'b1);
    tick(2, 1'b1, 8'hA1, 1'b0, 1'b1);
    tick(2, 1'b1, 8'hA2, 1'b0, 1'b1);
    tick(2, 1'b0, 8'h00, 1'b1, 1'b1);
    tick(2, 1'b1, 8'hA3, 1'b0, 1'b1);
    tests++; if (count[2] !== 3'd3) begin fails++; $display("FAIL wrap_count got %0d want 3", count[2]); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_data[2] !== exp[i]) begin fails++; $display("FAIL wrap_drain[%0d] got %h want %h", i, out_data[2], exp[i]); end
      tick(2, 1'b0, 8'h00, 1'b1, 1'b1);
    end
  endtask

  // P=1: simultaneous push and pop at count 1.
  task automatic test_back_to_back();
    tick(1, 1'b1, 8'h5A, 1'b0, 1'b1);
    tests++; if (out_data[1] !== 8'h5A) begin fails++; $display("FAIL b2b_head got %h want 5a", out_data[1]); end
    tick(1, 1'b1, 8'h5B, 1'b1, 1'b1);
    tests++; if (count[1] !== 3'd1) begin fails++; $display("FAIL b2b_count got %0d want 1", count[1]); end
    tests++; if (out_data[1] !== 8'h5B) begin fails++; $display("FAIL b2b_next got %h want 5b", out_data[1]); end
    tick(1, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // P=0: reset while data is queued and a push is offered.
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) tick(0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b1);
    tick(0, 1'b1, 8'h99, 1'b0, 1'b0);
    tests++; if (count[0] !== 3'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", count[0]); end
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got %b want 0", out_valid[0]); end
    tick(0, 1'b1, 8'h77, 1'b0, 1'b1);
    tests++; if (count[0] !== 3'd1) begin fails++; $display("FAIL rstmid_push_count got %0d want 1", count[0]); end
    tests++; if (out_data[0] !== 8'h77) begin fails++; $display("FAIL rstmid_data got %h want 77", out_data[0]); end
    tick(0, 1'b0, 8'h00, 1'b1, 1'b1);
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL rstmid_only_entry got %b want 0", out_valid[0]); end
  endtask

  // WIDTH=4 set reports DEPTH*4 bits.
  task automatic test_depth_bits();
    int exp4 [4];
    exp4[0] = 28; exp4[1] = 8; exp4[2] = 12; exp4[3] = 20;
    for (int d = 0; d < 4; d++) begin
      tests++; if (n_depth_bits[d] !== 32'(exp4[d])) begin fails++; $display("FAIL depth_bits_w4[%0d] got %0d want %0d", d, n_depth_bits[d], exp4[d]); end
    end
  endtask

  // Random traffic on every instance, holding an offered word until taken.
  task automatic test_random();
    for (int d = 0; d < 4; d++) begin
      logic       iv;
      logic [7:0] din;
      iv = 1'b0; din = 8'h00;
      for (int c = 0; c < 150; c++) begin
        logic ordy;
        if (!iv) begin
          iv  = ($urandom_range(0, 99) < 60);
          din = 8'($urandom);
        end
        ordy = ($urandom_range(0, 99) < 45);
        begin
          bit taken;
          taken = iv && (mcnt[d] != dep(d));
          tick(d, iv, din, ordy, 1'b1);
          if (taken) iv = 1'b0;
        end
        tests++; if (count[d] !== 3'(mcnt[d])) begin fails++; $display("FAIL rand_count[%0d] cyc %0d got %0d want %0d", d, c, count[d], mcnt[d]); end
        tests++; if (out_valid[d] !== (mcnt[d] != 0)) begin fails++; $display("FAIL rand_out_valid[%0d] cyc %0d got %b", d, c, out_valid[d]); end
        tests++; if (in_ready[d] !== (mcnt[d] != dep(d))) begin fails++; $display("FAIL rand_in_ready[%0d] cyc %0d got %b", d, c, in_ready[d]); end
        tests++; if (out_data[d] !== m_front(d)) begin fails++; $display("FAIL rand_out_data[%0d] cyc %0d got %h want %h", d, c, out_data[d], m_front(d)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_depth_bits();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
